// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry, sample/address types, loader states
// and the bit-reversal helper used by both the input loader and the FFT address generator.
package fft_pkg;

    localparam int unsigned N_POINTS = 512;
    localparam int unsigned ADDR_W   = 9;
    localparam int unsigned DATA_W   = 16;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic [ADDR_W-1:0]        addr_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } loader_state_t;

    function automatic addr_t bitrev(input addr_t a);
        addr_t r;
        r = '0;
        for (int unsigned i = 0; i < ADDR_W; i++) begin
            r[i] = a[ADDR_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_input_loader.sv
// Streams one frame of signed ADC samples into the FFT sample BRAM, scaling each
// sample to the BRAM word width and writing at bit-reversed addresses.
module fft_input_loader #(
    parameter int unsigned N_POINTS = 512,
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned IN_W     = 12,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned GUARD    = 2,
    parameter bit          BIT_REV  = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_smp_valid,
    input  logic [IN_W-1:0]   i_smp_data,
    output logic              o_smp_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_overrun
);

    import fft_pkg::*;

    localparam int unsigned SHIFT = DATA_W - IN_W - GUARD;

    if (IN_W + GUARD > DATA_W) begin : g_width_check
        $error("fft_input_loader: IN_W + GUARD exceeds DATA_W");
    end
    if (N_POINTS != (1 << ADDR_W)) begin : g_size_check
        $error("fft_input_loader: N_POINTS must equal 2**ADDR_W");
    end

    loader_state_t state_q, state_d;

    logic [ADDR_W-1:0]        k_q, k_d;
    logic                     wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
    logic signed [DATA_W-1:0] wr_data_q, wr_data_d;
    logic                     overrun_q, overrun_d;

    logic                     smp_ready;
    logic                     accept;
    logic [ADDR_W-1:0]        map_addr;
    logic signed [DATA_W-1:0] smp_ext;
    logic signed [DATA_W-1:0] smp_scaled;

    // The shared package helper only covers the default geometry; other widths reverse locally.
    if (!BIT_REV) begin : g_linear
        always_comb map_addr = k_q;
    end else if (ADDR_W == fft_pkg::ADDR_W) begin : g_bitrev_pkg
        always_comb map_addr = bitrev(k_q);
    end else begin : g_bitrev_local
        always_comb begin
            map_addr = '0;
            for (int unsigned i = 0; i < ADDR_W; i++) begin
                map_addr[i] = k_q[ADDR_W-1-i];
            end
        end
    end

    always_comb begin
        smp_ext    = DATA_W'($signed(i_smp_data));
        smp_scaled = smp_ext <<< SHIFT;
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        overrun_d = overrun_q;

        smp_ready = (state_q == LOAD);
        accept    = i_smp_valid && smp_ready;

        if (i_smp_valid && !smp_ready) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    k_d       = '0;
                    overrun_d = 1'b0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = map_addr;
                    wr_data_d = smp_scaled;
                    if (k_q == ADDR_W'(N_POINTS - 1)) begin
                        state_d = DONE;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        o_smp_ready  = smp_ready;
        o_wr_en      = wr_en_q;
        o_wr_addr    = wr_addr_q;
        o_wr_data    = wr_data_q;
        o_busy       = (state_q != IDLE);
        o_frame_done = (state_q == DONE);
        o_overrun    = overrun_q;
    end

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader: a bit-reversed instance and a linear-address
// instance driven by the same stimulus, with writes logged on the falling edge.
module tb_fft_input_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        valid;
    logic [11:0] data;

    logic        ready_a, wr_en_a, busy_a, done_a, ovr_a;
    logic [8:0]  addr_a;
    logic [15:0] wdat_a;
    logic        ready_b, wr_en_b, busy_b, done_b, ovr_b;
    logic [8:0]  addr_b;
    logic [15:0] wdat_b;

    int checks = 0;
    int errors = 0;

    int addr_log_a[$];
    int data_log_a[$];
    int addr_log_b[$];
    int done_cnt_a = 0;

    always #5 clk = ~clk;

    fft_input_loader #(.N_POINTS(512), .ADDR_W(9), .IN_W(12), .DATA_W(16), .GUARD(2), .BIT_REV(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_smp_valid(valid), .i_smp_data(data),
        .o_smp_ready(ready_a), .o_wr_en(wr_en_a), .o_wr_addr(addr_a), .o_wr_data(wdat_a),
        .o_busy(busy_a), .o_frame_done(done_a), .o_overrun(ovr_a)
    );

    fft_input_loader #(.N_POINTS(512), .ADDR_W(9), .IN_W(12), .DATA_W(16), .GUARD(2), .BIT_REV(1'b0)) dut_lin (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_smp_valid(valid), .i_smp_data(data),
        .o_smp_ready(ready_b), .o_wr_en(wr_en_b), .o_wr_addr(addr_b), .o_wr_data(wdat_b),
        .o_busy(busy_b), .o_frame_done(done_b), .o_overrun(ovr_b)
    );

    always @(negedge clk) begin
        if (wr_en_a) begin
            addr_log_a.push_back(int'(addr_a));
            data_log_a.push_back(int'(wdat_a));
        end
        if (wr_en_b) addr_log_b.push_back(int'(addr_b));
        if (done_a) done_cnt_a++;
    end

    function automatic int brev9(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 9; i++) begin
            if (v[i]) r = r | (1 << (8 - i));
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int base_a, base_b, base_done, bad, cyc, acc;

        rst = 1'b1; start = 1'b0; valid = 1'b1; data = 12'h0;
        step(); step(); step();
        chk("rst_wr_en", 32'(wr_en_a), 32'd0);
        chk("rst_addr", 32'(addr_a), 32'd0);
        chk("rst_data", 32'(wdat_a), 32'd0);
        chk("rst_ready", 32'(ready_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_overrun", 32'(ovr_a), 32'd0);

        rst = 1'b0; valid = 1'b0;
        step();
        chk("post_rst_overrun", 32'(ovr_a), 32'd0);
        chk("post_rst_writes", 32'(addr_log_a.size()), 32'd0);

        // Valid while idle: no write, sticky overrun, cleared by start
        valid = 1'b1; data = 12'h123;
        step();
        valid = 1'b0;
        step();
        chk("idle_overrun", 32'(ovr_a), 32'd1);
        chk("idle_no_write", 32'(addr_log_a.size()), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_clears_ovr", 32'(ovr_a), 32'd0);
        chk("load_ready", 32'(ready_a), 32'd1);
        chk("load_busy", 32'(busy_a), 32'd1);

        // Contiguous frame x=k
        base_a = addr_log_a.size(); base_b = addr_log_b.size(); base_done = done_cnt_a;
        for (int k = 0; k < 512; k++) begin
            valid = 1'b1; data = 12'(k);
            step();
            if (k == 0) chk("first_wr_latency", 32'(wr_en_a), 32'd1);
        end
        chk("last_wr_en", 32'(wr_en_a), 32'd1);
        chk("last_done", 32'(done_a), 32'd1);
        chk("last_addr", 32'(addr_a), 32'd511);
        chk("last_data", 32'(wdat_a), 32'd2044);
        chk("done_ready", 32'(ready_a), 32'd0);
        step();
        valid = 1'b0;
        chk("sample513_overrun", 32'(ovr_a), 32'd1);
        chk("sample513_no_wr", 32'(wr_en_a), 32'd0);
        chk("after_done_busy", 32'(busy_a), 32'd0);
        step();
        chk("frame_writes", 32'(addr_log_a.size() - base_a), 32'd512);
        chk("frame_done_pulses", 32'(done_cnt_a - base_done), 32'd1);
        chk("k1_addr", 32'(addr_log_a[base_a+1]), 32'd256);
        chk("k1_data", 32'(data_log_a[base_a+1]), 32'd4);
        chk("k2_addr", 32'(addr_log_a[base_a+2]), 32'd128);
        chk("k3_addr", 32'(addr_log_a[base_a+3]), 32'd384);
        chk("k3_data", 32'(data_log_a[base_a+3]), 32'd12);
        bad = 0;
        for (int k = 0; k < 512; k++) begin
            if (addr_log_a[base_a+k] != brev9(k)) bad++;
            if (data_log_a[base_a+k] != k * 4) bad++;
            if (addr_log_b[base_b+k] != k) bad++;
        end
        chk("frame_seq_bad", 32'(bad), 32'd0);

        // Extremes, then reset mid-frame after k=200
        start = 1'b1;
        step();
        start = 1'b0;
        valid = 1'b1; data = 12'h800;
        step();
        chk("ext_800", 32'(wdat_a), 32'h0000E000);
        data = 12'h7FF;
        step();
        chk("ext_7ff", 32'(wdat_a), 32'h00001FFC);
        data = 12'hFFF;
        step();
        chk("ext_fff", 32'(wdat_a), 32'h0000FFFC);
        for (int k = 3; k <= 200; k++) begin
            data = 12'(k);
            step();
        end
        chk("k200_addr", 32'(addr_a), 32'(brev9(200)));
        rst = 1'b1;
        step();
        chk("midrst_wr_en", 32'(wr_en_a), 32'd0);
        chk("midrst_busy", 32'(busy_a), 32'd0);
        chk("midrst_ready", 32'(ready_a), 32'd0);
        rst = 1'b0; valid = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        valid = 1'b1; data = 12'd5;
        step();
        chk("restart_wr_en", 32'(wr_en_a), 32'd1);
        chk("restart_addr", 32'(addr_a), 32'd0);
        chk("restart_data", 32'(wdat_a), 32'd20);
        valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        // Valid toggling every cycle
        start = 1'b1;
        step();
        start = 1'b0;
        base_a = addr_log_a.size(); base_b = addr_log_b.size(); base_done = done_cnt_a;
        acc = 0; cyc = 0;
        for (int c = 1; c <= 2000; c++) begin
            valid = c[0];
            data = 12'(acc);
            step();
            if (c[0]) acc++;
            cyc = c;
            if (done_a) break;
        end
        valid = 1'b0;
        chk("toggle_done_cycle", 32'(cyc), 32'd1023);
        step();
        step();
        chk("toggle_writes", 32'(addr_log_a.size() - base_a), 32'd512);
        chk("toggle_done_pulses", 32'(done_cnt_a - base_done), 32'd1);
        bad = 0;
        for (int k = 0; k < 512 && base_a + k < addr_log_a.size() && base_b + k < addr_log_b.size(); k++) begin
            if (addr_log_a[base_a+k] != brev9(k)) bad++;
            if (data_log_a[base_a+k] != k * 4) bad++;
            if (addr_log_b[base_b+k] != k) bad++;
        end
        chk("toggle_seq_bad", 32'(bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
